// File: rtl/mont_exp_ctrl_if.sv
// Operand/handshake bundle between the exponentiation sequencer and one
// montgomery multiplier core.
interface mont_exp_ctrl_if #(
  parameter int DATA_W = 1024
);
  logic              mont_start;
  logic [DATA_W-1:0] mont_a;
  logic [DATA_W-1:0] mont_b;
  logic [DATA_W-1:0] mont_m;
  logic [DATA_W-1:0] mont_result;
  logic              mont_done;

  // sequencer side
  modport master (
    output mont_start, mont_a, mont_b, mont_m,
    input  mont_result, mont_done
  );

  // multiplier core side
  modport slave (
    input  mont_start, mont_a, mont_b, mont_m,
    output mont_result, mont_done
  );
endinterface

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a single montgomery
// core. acc starts at R mod M (Montgomery "1"); a final multiply by plain 1
// takes the result out of the Montgomery domain.
module mont_exp_ctrl #(
  parameter int DATA_W = 1024,
  parameter int EXP_W  = 1024,
  parameter int LEN_W  = $clog2(EXP_W+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_m,
  input  logic [EXP_W-1:0]  in_e,
  input  logic [LEN_W-1:0]  in_e_len,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy,
  mont_exp_ctrl_if.master   mif
);

  typedef enum logic [2:0] {
    IDLE, SQ_START, SQ_WAIT, MUL_START, MUL_WAIT, POST_START, POST_WAIT, DONE
  } state_t;

  localparam logic [LEN_W-1:0]  EXP_W_L = LEN_W'(EXP_W);
  localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] x_q, m_q, acc;
  logic [EXP_W-1:0]  e_q, e_sh;
  logic [LEN_W-1:0]  idx, idx_dec, len_clamp;
  logic              cur_bit;
  logic              ms;
  logic [DATA_W-1:0] ma, mb;

  // lengths beyond the exponent register are clamped to its width
  assign len_clamp = (in_e_len > EXP_W_L) ? EXP_W_L : in_e_len;
  assign idx_dec   = idx - 1'b1;
  // bit being consumed by the square that is completing (idx >= 1 in SQ_WAIT)
  assign e_sh      = e_q >> idx_dec;
  assign cur_bit   = e_sh[0];

  assign mif.mont_start = ms;
  assign mif.mont_a     = ma;
  assign mif.mont_b     = mb;
  assign mif.mont_m     = m_q;
  assign result         = acc;
  assign done           = (state_q == DONE);
  assign busy           = (state_q != IDLE);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state and core operand selection; the NEXT decision is folded into
  // the capturing transition so it costs no cycle
  always_comb begin
    state_d = state_q;
    ms      = 1'b0;
    ma      = acc;
    mb      = acc;
    case (state_q)
      IDLE:       if (start) state_d = (len_clamp == '0) ? POST_START : SQ_START;
      SQ_START: begin
        ms      = 1'b1;
        state_d = SQ_WAIT;
      end
      SQ_WAIT: begin
        if (mif.mont_done) begin
          if (cur_bit)               state_d = MUL_START;
          else if (idx_dec == '0)    state_d = POST_START;
          else                       state_d = SQ_START;
        end
      end
      MUL_START: begin
        ms      = 1'b1;
        mb      = x_q;
        state_d = MUL_WAIT;
      end
      MUL_WAIT: begin
        mb = x_q;
        if (mif.mont_done) state_d = (idx == '0) ? POST_START : SQ_START;
      end
      POST_START: begin
        ms      = 1'b1;
        mb      = ONE;
        state_d = POST_WAIT;
      end
      POST_WAIT: begin
        mb = ONE;
        if (mif.mont_done) state_d = DONE;
      end
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // command latch, accumulator capture and bit index countdown
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      m_q <= '0;
      e_q <= '0;
      acc <= '0;
      idx <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q <= in_x;
            m_q <= in_m;
            e_q <= in_e;
            acc <= in_r;
            idx <= len_clamp;
          end
        end
        SQ_WAIT: begin
          if (mif.mont_done) begin
            acc <= mif.mont_result;
            idx <= idx_dec;
          end
        end
        MUL_WAIT, POST_WAIT: begin
          if (mif.mont_done) acc <= mif.mont_result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: fixed-latency montgomery core model, scoreboard of
// expected core operands and results, cycle-accurate done/busy tracking.
module tb_mont_exp_ctrl;
  localparam int DATA_W = 16;
  localparam int EXP_W  = 8;
  localparam int LEN_W  = $clog2(EXP_W+1);
  localparam int D      = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] in_x = '0, in_r = '0, in_m = '0;
  logic [EXP_W-1:0]  in_e = '0;
  logic [LEN_W-1:0]  in_e_len = '0;
  logic [DATA_W-1:0] result;
  logic              done, busy;

  mont_exp_ctrl_if #(.DATA_W(DATA_W)) mif();

  mont_exp_ctrl #(.DATA_W(DATA_W), .EXP_W(EXP_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x(in_x), .in_r(in_r), .in_m(in_m), .in_e(in_e), .in_e_len(in_e_len),
    .result(result), .done(done), .busy(busy), .mif(mif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  longint tb_m = 13, tb_rinv = 1;

  function automatic longint mont(input longint a, input longint b);
    return (((a * b) % tb_m) * tb_rinv) % tb_m;
  endfunction

  function automatic longint mod_pow(input longint x, input int e, input int len, input longint m);
    longint r = 1;
    for (int i = len - 1; i >= 0; i--) begin
      r = (r * r) % m;
      if (e[i]) r = (r * x) % m;
    end
    return r % m;
  endfunction

  // core model
  logic [DATA_W-1:0] core_a = '0, core_b = '0, mres = '0;
  logic              mdone = 1'b0, spur = 1'b0, core_pend = 1'b0;
  int                core_dcyc = 0;
  assign mif.mont_done   = mdone | spur;
  assign mif.mont_result = mres;

  always @(posedge clk) begin
    #1;
    if (core_pend && cyc == core_dcyc) begin
      mdone     = 1'b1;
      mres      = DATA_W'(mont(core_a, core_b));
      core_pend = 1'b0;
    end else begin
      mdone = 1'b0;
    end
  end

  // scoreboard
  logic [2*DATA_W-1:0] op_q[$];
  logic [DATA_W-1:0]   res_q[$];
  int                  dcyc_q[$];
  int                  nops_q[$];
  int                  ms_cnt = 0, n_done = 0, last_n = 0;
  int                  act_lo = -1, act_hi = -1;
  logic                prev_ms = 1'b0;
  logic [2*DATA_W-1:0] exp_op;
  logic [DATA_W-1:0]   exp_res;
  int                  exp_dc, exp_n;

  always @(negedge clk) begin
    if (reset) begin
      op_q.delete(); res_q.delete(); dcyc_q.delete(); nops_q.delete();
      core_pend = 1'b0;
      ms_cnt    = 0;
      prev_ms   = 1'b0;
      if (act_hi > cyc) act_hi = cyc;
    end else begin
      chk("busy", busy, (cyc >= act_lo && cyc <= act_hi));
      chk("done_pulse", done, (cyc == act_hi));
      if (mdone) chk("op_hold", {mif.mont_a, mif.mont_b}, {core_a, core_b});
      if (mif.mont_start) begin
        chk("start_gap", prev_ms, 0);
        chk("mont_m", mif.mont_m, tb_m);
        chk("op_avail", op_q.size() != 0, 1);
        if (op_q.size() != 0) begin
          exp_op = op_q.pop_front();
          chk("operands", {mif.mont_a, mif.mont_b}, exp_op);
        end
        ms_cnt++;
        core_a    = mif.mont_a;
        core_b    = mif.mont_b;
        core_pend = 1'b1;
        core_dcyc = cyc + D;
      end
      prev_ms = mif.mont_start;
      if (done) begin
        n_done++;
        chk("res_avail", res_q.size() != 0, 1);
        if (res_q.size() != 0) begin
          exp_res = res_q.pop_front();
          exp_dc  = dcyc_q.pop_front();
          exp_n   = nops_q.pop_front();
          chk("result", result, exp_res);
          chk("done_cyc", cyc, exp_dc);
          chk("n_ops", ms_cnt, exp_n);
          chk("ops_left", op_q.size(), 0);
        end
        last_n = ms_cnt;
        ms_cnt = 0;
      end
    end
  end

  // drives one command; returns #1 into the first cycle after acceptance
  task automatic issue_cmd(input int x, input int e, input int len, input int m);
    longint rm, xm, acc;
    int     L, n;
    tb_m    = m;
    rm      = (longint'(1) << DATA_W) % m;
    tb_rinv = 0;
    for (int k = 1; k < m; k++) if ((rm * k) % m == 1) tb_rinv = k;
    xm  = (x * rm) % m;
    L   = (len > EXP_W) ? EXP_W : len;
    acc = rm;
    n   = 0;
    for (int i = L - 1; i >= 0; i--) begin
      op_q.push_back({DATA_W'(acc), DATA_W'(acc)});
      acc = mont(acc, acc);
      n++;
      if (e[i]) begin
        op_q.push_back({DATA_W'(acc), DATA_W'(xm)});
        acc = mont(acc, xm);
        n++;
      end
    end
    op_q.push_back({DATA_W'(acc), DATA_W'(1)});
    n++;
    @(posedge clk); #1;
    in_x = DATA_W'(xm); in_r = DATA_W'(rm); in_m = DATA_W'(m);
    in_e = EXP_W'(e);   in_e_len = LEN_W'(len);
    start = 1'b1;
    res_q.push_back(DATA_W'(mod_pow(x, e, L, m)));
    dcyc_q.push_back(cyc + 1 + n * (D + 1));
    nops_q.push_back(n);
    act_lo = cyc + 1;
    act_hi = cyc + 1 + n * (D + 1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // returns #1 after the negedge of the done cycle
  task automatic wait_done();
    int n0 = n_done;
    int k  = 0;
    while (n_done == n0 && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("done_timeout", n_done != n0, 1);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mstart", mif.mont_start, 0);
    @(posedge clk); #1 reset = 1'b0;

    issue_cmd(3, 'h5, 3, 13);    wait_done(); chk("t1_res", result, 9); chk("t1_n", last_n, 6);
    issue_cmd(2, 'hF, 4, 13);    wait_done(); chk("t2_res", result, 8); chk("t2_n", last_n, 9);
    issue_cmd(5, 'hA3, 0, 13);   wait_done(); chk("t3_res", result, 1); chk("t3_n", last_n, 1);
    issue_cmd(2, 'h81, 12, 13);  wait_done(); chk("t4_res", result, 5); chk("t4_n", last_n, 11);
    issue_cmd(10, 'hB7, 8, 97);  wait_done(); chk("t5_n", last_n, 15);

    // ignored start/done pulses while busy, in DONE and in IDLE
    issue_cmd(3, 'h5, 3, 13);
    spur = 1'b1;                         // lands in SQ_START
    @(posedge clk); #1 spur = 1'b0;
    in_x = '1; start = 1'b1;             // lands in SQ_WAIT
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    start = 1'b1;                        // lands in DONE
    @(posedge clk); #1 start = 1'b0;
    spur = 1'b1;                         // lands in IDLE
    @(posedge clk); #1 spur = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("t6_res_held", result, 9);
    chk("t6_idle", busy, 0);
    chk("t6_no_ops", ms_cnt, 0);

    // reset during MUL_WAIT
    issue_cmd(2, 'hF, 4, 13);
    k = 0;
    while (ms_cnt < 2 && k < 100) begin @(negedge clk); #1; k++; end
    chk("t7_reach_mul", ms_cnt, 2);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    chk("t7_result", result, 0);
    chk("t7_mstart", mif.mont_start, 0);
    issue_cmd(2, 'hF, 4, 13);    wait_done(); chk("t7_res", result, 8); chk("t7_n", last_n, 9);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
